fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter HALT_ON_ZERO, default 1, enables halt when the fetched word is 32'h0000_0000.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 stall  input  1  hold PC and IF/ID register this cycle.
REQ-006 redirect_valid  input  1  branch/jump taken; load redirect_pc and flush IF/ID.
REQ-007 redirect_pc  input  32  redirect target byte address.
REQ-008 imem_addr  output  32  byte address to instruction memory (word index = addr>>2).
REQ-009 imem_inst  input  32  instruction word returned combinationally for imem_addr.
REQ-010 if_id_valid  output  1  IF/ID register holds a real instruction.
REQ-011 if_id_pc  output  32  byte address of the held instruction.
REQ-012 if_id_pc_plus4  output  32  if_id_pc + 4, modulo 2^32.
REQ-013 if_id_inst  output  32  held instruction word.
REQ-014 halted  output  1  state machine is in HALT.
REQ-015 fetch_count  output  32  number of instructions delivered into IF/ID since reset.

Function
REQ-016 The unit SHALL hold a 32-bit PC register and drive imem_addr = PC combinationally, with no added latency.
REQ-017 The state machine SHALL have two states, RUN and HALT, and SHALL enter RUN on reset.
REQ-018 In RUN with no stall and no redirect, when imem_inst != 0 or HALT_ON_ZERO = 0, the unit SHALL:
  - capture PC, PC+4 and imem_inst into IF/ID;
  - set if_id_valid = 1;
  - load PC+4 into PC;
  - increment fetch_count.
REQ-019 In RUN with no stall and no redirect, when HALT_ON_ZERO = 1 and imem_inst == 0, the unit SHALL:
  - clear if_id_valid;
  - hold PC;
  - leave fetch_count unchanged;
  - go to HALT.
REQ-020 When stall = 1 and redirect_valid = 0, PC, all IF/ID fields, fetch_count and state SHALL hold their values.
REQ-021 When redirect_valid = 1, the unit SHALL load {redirect_pc[31:2], 2'b00} into PC and clear if_id_valid, in any state and regardless of stall. Redirect has priority over both stall and zero-detect.
REQ-022 A redirect in HALT SHALL return the state machine to RUN, and fetching SHALL resume from the redirect target on the next cycle.
REQ-023 In HALT without redirect, PC SHALL hold, if_id_valid SHALL be 0, and fetch_count SHALL hold.
REQ-024 halted SHALL be 1 exactly when state == HALT (registered, no combinational path from imem_inst).
REQ-025 PC increment SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0), with no error indication.
REQ-026 fetch_count SHALL saturate at 32'hFFFF_FFFF.
REQ-027 When if_id_valid = 0, if_id_pc, if_id_pc_plus4 and if_id_inst SHALL hold their last values (don't-care to consumers).
REQ-028 PC bits [1:0] SHALL always be 0.

Reset
REQ-029 When rst_n = 0 at a rising clk edge, the unit SHALL set the following, overriding stall and redirect:
  - PC = RESET_PC;
  - state = RUN;
  - if_id_valid = 0;
  - if_id_pc = 0, if_id_pc_plus4 = 0, if_id_inst = 0;
  - fetch_count = 0.
REQ-030 Reset asserted mid-operation (including during HALT or stall) SHALL produce the same state as REQ-029 on that edge.
REQ-031 The first fetch SHALL occur on the first rising edge with rst_n = 1, and the first valid IF/ID entry SHALL be visible one cycle after reset release.

Verification
REQ-032 Memory preloaded with 00500093, 00A08113, 002081B3, 00208263, 01400213, 01E00293, then zeros; release reset; no stall or redirect. Required response:
  - IF/ID shows pc 0x00..0x14 with those words on 6 consecutive cycles;
  - halted = 1 on the 7th cycle;
  - fetch_count = 6;
  - imem_addr stays at 0x18.
REQ-033 Same program, stall = 1 for 2 cycles while IF/ID holds pc 0x04 -> IF/ID holds pc 0x04 / 00A08113 for those 2 cycles, imem_addr stays 0x08, and fetch_count does not advance.
REQ-034 Redirect_valid = 1 with redirect_pc = 0x13 while stall = 1 -> next cycle PC = 0x10 and if_id_valid = 0; the following cycle IF/ID holds pc 0x10 / 01400213.
REQ-035 In HALT at PC 0x18, redirect_pc = 0x00 -> halted = 0 next cycle, and the program re-executes from 0x00 with fetch_count continuing from 6.
REQ-036 rst_n = 0 for one cycle while IF/ID holds pc 0x0C -> next cycle PC = RESET_PC, if_id_valid = 0, fetch_count = 0, halted = 0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register,
// RUN/HALT control with zero-word halt and redirect handling.
module fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter bit          HALT_ON_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic [31:0] if_id_inst,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  localparam logic [31:0] ALIGN = 32'hFFFF_FFFC;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_valid;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_pc4;
  logic [31:0] r_id_inst;
  logic [31:0] r_count;

  logic [31:0] w_pc_plus4;
  logic        w_take;
  logic [31:0] w_count_inc;

  assign w_pc_plus4  = r_pc + 32'd4;
  assign w_take      = (imem_inst != 32'd0) || !HALT_ON_ZERO;
  assign w_count_inc = (r_count == 32'hFFFF_FFFF) ? r_count
                                                  : r_count + 32'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_RUN;
      r_pc      <= RESET_PC & ALIGN;
      r_valid   <= 1'b0;
      r_id_pc   <= 32'd0;
      r_id_pc4  <= 32'd0;
      r_id_inst <= 32'd0;
      r_count   <= 32'd0;
    end else if (redirect_valid) begin
      // redirect beats stall and zero-detect, and wakes from HALT
      r_state <= S_RUN;
      r_pc    <= redirect_pc & ALIGN;
      r_valid <= 1'b0;
    end else if (!stall) begin
      unique case (r_state)
        S_RUN: begin
          if (w_take) begin
            r_id_pc   <= r_pc;
            r_id_pc4  <= w_pc_plus4;
            r_id_inst <= imem_inst;
            r_valid   <= 1'b1;
            r_pc      <= w_pc_plus4;
            r_count   <= w_count_inc;
          end else begin
            r_valid <= 1'b0;
            r_state <= S_HALT;
          end
        end
        S_HALT: begin
          r_valid <= 1'b0;
        end
        default: begin
          r_state <= S_RUN;
        end
      endcase
    end
  end

  assign imem_addr      = r_pc;
  assign if_id_valid    = r_valid;
  assign if_id_pc       = r_id_pc;
  assign if_id_pc_plus4 = r_id_pc4;
  assign if_id_inst     = r_id_inst;
  assign halted         = (r_state == S_HALT);
  assign fetch_count    = r_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed program plus random
// stall/redirect/reset traffic against a behavioural fetch model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic [31:0] if_id_inst;
  logic        halted;
  logic [31:0] fetch_count;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .HALT_ON_ZERO(1'b1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_addr     (imem_addr),
    .imem_inst     (imem_inst),
    .if_id_valid   (if_id_valid),
    .if_id_pc      (if_id_pc),
    .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_inst    (if_id_inst),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  logic [31:0] mem [64];
  assign imem_inst = mem[imem_addr[7:2]];

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic [31:0] ipc;
    logic [31:0] ipc4;
    logic [31:0] inst;
    logic        halt;
    logic [31:0] cnt;
  } snap_t;

  snap_t m;
  snap_t q[$];
  int    total = 0;
  int    bad   = 0;
  bit    fill_pending = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: one clock of fetch behaviour from the rules, as arithmetic.
  task automatic model_step(input bit rst, input bit st, input bit rv,
                            input logic [31:0] rp);
    logic [31:0] w;
    if (rst) begin
      m = '{pc: 0, valid: 0, ipc: 0, ipc4: 0, inst: 0, halt: 0, cnt: 0};
    end else if (rv) begin
      m.pc    = rp - (rp % 4);
      m.valid = 0;
      m.halt  = 0;
    end else if (st) begin
    end else if (m.halt) begin
      m.valid = 0;
    end else begin
      w = mem[(m.pc / 4) % 64];
      if (w == 0) begin
        m.valid = 0;
        m.halt  = 1;
      end else begin
        m.ipc   = m.pc;
        m.ipc4  = m.pc + 4;
        m.inst  = w;
        m.valid = 1;
        m.pc    = m.pc + 4;
        if (m.cnt != 32'hFFFF_FFFF) m.cnt = m.cnt + 1;
      end
    end
  endtask

  task automatic cycle(input bit rst, input bit st, input bit rv,
                       input logic [31:0] rp);
    @(negedge clk);
    if (fill_pending) begin
      for (int i = 0; i < 64; i++)
        mem[i] = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      fill_pending = 0;
    end
    rst_n          = !rst;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rp;
    model_step(rst, st, rv, rp);
    q.push_back(m);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 32'd0);
  endtask

  initial begin : monitor
    snap_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("imem_addr", imem_addr, e.pc);
        chk("valid", {31'd0, if_id_valid}, {31'd0, e.valid});
        chk("id_pc", if_id_pc, e.ipc);
        chk("id_pc4", if_id_pc_plus4, e.ipc4);
        chk("id_inst", if_id_inst, e.inst);
        chk("halted", {31'd0, halted}, {31'd0, e.halt});
        chk("count", fetch_count, e.cnt);
      end
    end
  end

  initial begin : stim
    rst_n = 0; stall = 0; redirect_valid = 0; redirect_pc = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    mem[0] = 32'h00500093; mem[1] = 32'h00A08113;
    mem[2] = 32'h002081B3; mem[3] = 32'h00208263;
    mem[4] = 32'h01400213; mem[5] = 32'h01E00293;
    m = '{pc: 0, valid: 0, ipc: 0, ipc4: 0, inst: 0, halt: 0, cnt: 0};

    cycle(1, 0, 0, 0);
    cycle(1, 1, 1, 32'h40);
    run(9);
    cycle(0, 0, 1, 32'h0);
    run(2);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    run(1);
    cycle(0, 1, 1, 32'h13);
    run(3);
    cycle(0, 0, 1, 32'h0);
    run(4);
    cycle(1, 0, 0, 0);
    run(8);
    mem[63] = 32'h00000013;
    cycle(0, 0, 1, 32'hFFFF_FFFE);
    run(3);
    cycle(0, 0, 1, 32'h14);
    run(3);
    cycle(1, 1, 0, 0);

    for (int k = 0; k < 600; k++) begin
      int r;
      if (k % 150 == 0) fill_pending = 1;
      r = $urandom_range(0, 99);
      cycle(r < 2, $urandom_range(0, 99) < 20, r >= 2 && r < 12,
            ($urandom_range(0, 3) == 0) ? $urandom
                                        : 32'($urandom_range(0, 255)));
    end
    cycle(0, 0, 0, 0);

    @(posedge clk);
    #3;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
